ntt_mem_sched: RTL and testbench

//  Initiator/scheduler for the dual-port coefficient BRAM in the NTT datapath. On start it

---
 rtl/ntt_mem_sched_if.sv | 49 ++++
 rtl/ntt_mem_sched.sv | 128 ++++++++++++
 tb/tb_ntt_mem_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_mem_sched_if.sv
// Bus bundle linking ntt_mem_sched to the dual-port coefficient BRAM and the butterfly unit.
// The inv line exists only when NTT_INVERSE_EN is defined.
interface ntt_mem_sched_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WIDTH      = 32
);
   logic                  start;
   logic                  busy;
   logic                  done;
`ifdef NTT_INVERSE_EN
   logic                  inv;
`endif
   logic                  en_a;
   logic                  en_b;
   logic                  we_a;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] raddr_a;
   logic [ADDR_WIDTH-1:0] raddr_b;
   logic [ADDR_WIDTH-1:0] waddr_a;
   logic [ADDR_WIDTH-1:0] waddr_b;
   logic [WIDTH-1:0]      din_a;
   logic [WIDTH-1:0]      din_b;
   logic [WIDTH-1:0]      dout_a;
   logic [WIDTH-1:0]      dout_b;
   logic                  bf_valid_o;
   logic [WIDTH-1:0]      bf_a_o;
   logic [WIDTH-1:0]      bf_b_o;
   logic [6:0]            zeta_idx;
   logic [WIDTH-1:0]      bf_a_i;
   logic [WIDTH-1:0]      bf_b_i;

   modport master (
      input  start, dout_a, dout_b, bf_a_i, bf_b_i,
`ifdef NTT_INVERSE_EN
      input  inv,
`endif
      output busy, done, en_a, en_b, we_a, we_b, raddr_a, raddr_b, waddr_a, waddr_b,
             din_a, din_b, bf_valid_o, bf_a_o, bf_b_o, zeta_idx
   );

   modport slave (
      output start, dout_a, dout_b, bf_a_i, bf_b_i,
`ifdef NTT_INVERSE_EN
      output inv,
`endif
      input  busy, done, en_a, en_b, we_a, we_b, raddr_a, raddr_b, waddr_a, waddr_b,
             din_a, din_b, bf_valid_o, bf_a_o, bf_b_o, zeta_idx
   );
endinterface

// File: rtl/ntt_mem_sched.sv
// Kyber NTT coefficient-BRAM scheduler: 7 layers x 128 in-place butterflies, one issue per cycle.
// Define NTT_INVERSE_EN to add the inv input and the Gentleman-Sande (inverse) ordering.
module ntt_mem_sched #(
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int WIDTH      = 32,
   parameter int BF_LAT     = 3
) (
   input logic             clk,
   input logic             rst,
   ntt_mem_sched_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [6:0]            k;
   logic [2:0]            layer;
   logic                  issue, wr, pipe_busy;
   logic [2:0]            s;
   logic [ADDR_WIDTH-1:0] kk, hi, j, j_len;
   logic [6:0]            zeta, zeta_q;
   logic [BF_LAT:0]       vld;
   logic [ADDR_WIDTH-1:0] pa [BF_LAT+1];
   logic [ADDR_WIDTH-1:0] pb [BF_LAT+1];
`ifdef NTT_INVERSE_EN
   logic                  inv_q;
`endif

   assign issue     = (state == S_ISSUE);
   assign wr        = vld[BF_LAT];
   assign pipe_busy = |vld[BF_LAT-1:0];

   // s = log2(len); j = (k/len)*2*len + k%len, and j+len just sets bit s of j.
`ifdef NTT_INVERSE_EN
   assign s    = inv_q ? layer + 3'd1 : 3'd7 - layer;
`else
   assign s    = 3'd7 - layer;
`endif
   assign kk    = ADDR_WIDTH'(k);
   assign hi    = kk >> s;
   assign j     = (hi << (4'(s) + 4'd1)) | (kk & ((ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1)));
   assign j_len = j | (ADDR_WIDTH'(1) << s);
`ifdef NTT_INVERSE_EN
   assign zeta  = inv_q ? 7'((8'd128 >> layer) - 8'd1 - 8'(hi)) : (7'd1 << layer) + 7'(hi);
`else
   assign zeta  = (7'd1 << layer) + 7'(hi);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_ISSUE;
         S_ISSUE: if (k == 7'd127) state_nxt = S_DRAIN;
         S_DRAIN: if (!pipe_busy) state_nxt = (layer == 3'd6) ? S_DONE : S_ISSUE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         k     <= '0;
         layer <= '0;
`ifdef NTT_INVERSE_EN
         inv_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               k     <= '0;
               layer <= '0;
`ifdef NTT_INVERSE_EN
               inv_q <= bus.inv;
`endif
            end
            S_ISSUE: k <= k + 7'd1;
            S_DRAIN: if (state_nxt == S_ISSUE) layer <= layer + 3'd1;
            default: ;
         endcase
      end
   end

   // Stage i of vld/pa/pb describes the pair issued i+1 cycles ago; the last stage writes back.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld    <= '0;
         zeta_q <= '0;
      end else begin
         vld    <= {vld[BF_LAT-1:0], issue};
         zeta_q <= issue ? zeta : 7'd0;
      end
   end

   // NOTE: the address delay line has no reset; its entries only matter where vld marks them.
   always_ff @(posedge clk) begin
      pa[0] <= j;
      pb[0] <= j_len;
      for (int i = 1; i <= BF_LAT; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_DONE);
   assign bus.en_a       = issue | wr;
   assign bus.en_b       = issue | wr;
   assign bus.we_a       = wr;
   assign bus.we_b       = wr;
   assign bus.raddr_a    = issue ? j     : '0;
   assign bus.raddr_b    = issue ? j_len : '0;
   assign bus.waddr_a    = wr ? pa[BF_LAT] : '0;
   assign bus.waddr_b    = wr ? pb[BF_LAT] : '0;
   assign bus.din_a      = wr ? bus.bf_a_i : '0;
   assign bus.din_b      = wr ? bus.bf_b_i : '0;
   // The BRAM output register is the operand stage; gating keeps the operands 0 between pairs.
   assign bus.bf_valid_o = vld[0];
   assign bus.bf_a_o     = vld[0] ? bus.dout_a : '0;
   assign bus.bf_b_o     = vld[0] ? bus.dout_b : '0;
   assign bus.zeta_idx   = zeta_q;
endmodule

// File: tb/tb_ntt_mem_sched.sv
// Directed bench for ntt_mem_sched: BRAM and butterfly models, cycle schedule and final-memory checks.
// Define NTT_INVERSE_EN to add the inverse-order run.
module tb_ntt_mem_sched;
   localparam int BF_LAT  = 3;
   localparam int PERIOD  = 129 + BF_LAT;
   localparam int RUN_CYC = 7 * PERIOD + 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_mem_sched_if #(.ADDR_WIDTH(8), .WIDTH(32)) bus ();

   ntt_mem_sched #(.DEPTH(256), .ADDR_WIDTH(8), .WIDTH(32), .BF_LAT(BF_LAT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [256];
   logic [31:0] img [256];
   logic        load_req = 1'b0;
   int          bf_mode  = 1;
   logic [31:0] qa [BF_LAT];
   logic [31:0] qb [BF_LAT];

   int exp_ra [896];
   int exp_rb [896];
   int exp_z  [896];
   int log_ra [0:RUN_CYC];
   int log_rb [0:RUN_CYC];
   int log_wa [0:RUN_CYC];
   int log_wb [0:RUN_CYC];
   int log_z  [0:RUN_CYC];
   bit log_we [0:RUN_CYC];
   bit log_done [0:RUN_CYC];
   bit log_busy [0:RUN_CYC];

   // Mode 0: identity; mode 1: (a+b, a-b+zeta) so wrong pairing or zeta shows in memory.
   function automatic logic [63:0] bfly(input int mode, input logic [31:0] a, input logic [31:0] b,
                                        input logic [6:0] z);
      if (mode == 0) return {a, b};
      return {a + b, a - b + {25'd0, z}};
   endfunction

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else begin
         if (bus.en_a && bus.we_a) mem[bus.waddr_a] <= bus.din_a;
         if (bus.en_b && bus.we_b) mem[bus.waddr_b] <= bus.din_b;
      end
      if (bus.en_a) bus.dout_a <= mem[bus.raddr_a];
      if (bus.en_b) bus.dout_b <= mem[bus.raddr_b];
   end

   always @(posedge clk) begin
      {qa[0], qb[0]} <= bfly(bf_mode, bus.bf_a_o, bus.bf_b_o, bus.zeta_idx);
      for (int i = 1; i < BF_LAT; i++) begin
         qa[i] <= qa[i-1];
         qb[i] <= qb[i-1];
      end
   end
   assign bus.bf_a_i = qa[BF_LAT-1];
   assign bus.bf_b_i = qb[BF_LAT-1];

   function automatic bit is_issue(input int c);
      if (c < 1) return 1'b0;
      return ((c - 1) / PERIOD < 7) && ((c - 1) % PERIOD < 128);
   endfunction

   function automatic int idx_of(input int c);
      return ((c - 1) / PERIOD) * 128 + (c - 1) % PERIOD;
   endfunction

   // Reference order from the textbook Kyber loops (per-block zeta counter).
   task automatic build_sched(input bit inv_v);
      int n = 0;
      int zk;
      if (!inv_v) begin
         zk = 1;
         for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
               for (int jj = st; jj < st + len; jj++) begin
                  exp_ra[n] = jj; exp_rb[n] = jj + len; exp_z[n] = zk; n++;
               end
               zk++;
            end
      end else begin
         zk = 127;
         for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
               for (int jj = st; jj < st + len; jj++) begin
                  exp_ra[n] = jj; exp_rb[n] = jj + len; exp_z[n] = zk; n++;
               end
               zk--;
            end
      end
   endtask

   task automatic load_mem();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   task automatic run_transform(input bit inv_v, input int mode, input bit second_start,
                                output int dones);
      logic [31:0] ref_m [256];
      logic [63:0] r;
      build_sched(inv_v);
      bf_mode = mode;
      for (int i = 0; i < 256; i++) ref_m[i] = img[i];
      for (int n = 0; n < 896; n++) begin
         r = bfly(mode, ref_m[exp_ra[n]], ref_m[exp_rb[n]], 7'(exp_z[n]));
         ref_m[exp_ra[n]] = r[63:32];
         ref_m[exp_rb[n]] = r[31:0];
      end
      dones = 0;
      @(negedge clk);
      log_busy[0] = bus.busy;
      bus.start = 1'b1;
`ifdef NTT_INVERSE_EN
      bus.inv = inv_v;
`endif
      for (int c = 1; c <= RUN_CYC; c++) begin
         int  cw;
         bit  iss, wrx, bv, eb, ed;
         @(negedge clk);
         bus.start = second_start && (c == 50 || c == 7 * PERIOD + 1);
         iss = is_issue(c);
         cw  = c - 1 - BF_LAT;
         wrx = is_issue(cw);
         bv  = is_issue(c - 1);
         eb  = (c <= 7 * PERIOD + 1);
         ed  = (c == 7 * PERIOD + 1);
         log_ra[c] = int'(bus.raddr_a); log_rb[c] = int'(bus.raddr_b);
         log_wa[c] = int'(bus.waddr_a); log_wb[c] = int'(bus.waddr_b);
         log_z[c]  = int'(bus.zeta_idx);
         log_we[c] = bus.we_a; log_done[c] = bus.done; log_busy[c] = bus.busy;
         if (bus.done) dones++;
         total++;
         if ({bus.busy, bus.done, bus.en_a, bus.en_b, bus.we_a, bus.we_b, bus.bf_valid_o} !==
             {eb, ed, iss | wrx, iss | wrx, wrx, wrx, bv}) begin
            bad++;
            $display("FAIL ctrl cycle %0d: busy,done,en_a,en_b,we_a,we_b,bf_valid got %b want %b", c,
                     {bus.busy, bus.done, bus.en_a, bus.en_b, bus.we_a, bus.we_b, bus.bf_valid_o},
                     {eb, ed, iss | wrx, iss | wrx, wrx, wrx, bv});
         end
         if (iss) begin
            total++;
            if ({bus.raddr_a, bus.raddr_b} !== {8'(exp_ra[idx_of(c)]), 8'(exp_rb[idx_of(c)])}) begin
               bad++;
               $display("FAIL raddr cycle %0d: got (%0d,%0d) want (%0d,%0d)", c, bus.raddr_a,
                        bus.raddr_b, exp_ra[idx_of(c)], exp_rb[idx_of(c)]);
            end
         end
         if (wrx) begin
            total++;
            if ({bus.waddr_a, bus.waddr_b, bus.din_a, bus.din_b} !==
                {8'(exp_ra[idx_of(cw)]), 8'(exp_rb[idx_of(cw)]), bus.bf_a_i, bus.bf_b_i}) begin
               bad++;
               $display("FAIL write cycle %0d: got waddr (%0d,%0d) din (%h,%h) want (%0d,%0d) (%h,%h)",
                        c, bus.waddr_a, bus.waddr_b, bus.din_a, bus.din_b, exp_ra[idx_of(cw)],
                        exp_rb[idx_of(cw)], bus.bf_a_i, bus.bf_b_i);
            end
         end
         if (bv) begin
            total++;
            if (bus.zeta_idx !== 7'(exp_z[idx_of(c - 1)])) begin
               bad++;
               $display("FAIL zeta cycle %0d: got %0d want %0d", c, bus.zeta_idx, exp_z[idx_of(c - 1)]);
            end
         end
      end
      for (int i = 0; i < 256; i++) begin
         total++;
         if (mem[i] !== ref_m[i]) begin
            bad++;
            $display("FAIL mem[%0d]: got %h want %h", i, mem[i], ref_m[i]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.en_a, bus.en_b, bus.we_a, bus.we_b, bus.raddr_a, bus.raddr_b,
           bus.waddr_a, bus.waddr_b, bus.din_a, bus.din_b, bus.bf_valid_o, bus.bf_a_o, bus.bf_b_o,
           bus.zeta_idx} !== '0) begin
         bad++;
         $display("FAIL reset outputs: got nonzero (busy=%b en_a=%b we_a=%b zeta=%0d) want all 0",
                  bus.busy, bus.en_a, bus.we_a, bus.zeta_idx);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.busy, bus.en_a, bus.we_a, bus.bf_valid_o} !== 4'b0) begin
         bad++;
         $display("FAIL idle after reset: got %b want 0000", {bus.busy, bus.en_a, bus.we_a, bus.bf_valid_o});
      end
   endtask

   task automatic test_forward_run();
      int d;
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      load_mem();
      run_transform(1'b0, 1, 1'b0, d);
      total++;
      if (d !== 1) begin
         bad++;
         $display("FAIL forward done count: got %0d want 1", d);
      end
   endtask

   task automatic test_first_layer();
      total++;
      if ({log_ra[1], log_rb[1], log_z[2]} !== {32'd0, 32'd128, 32'd1}) begin
         bad++;
         $display("FAIL first issue: got (%0d,%0d) z=%0d want (0,128) z=1", log_ra[1], log_rb[1], log_z[2]);
      end
      total++;
      if ({log_ra[128], log_rb[128], log_z[129]} !== {32'd127, 32'd255, 32'd1}) begin
         bad++;
         $display("FAIL last layer0 issue: got (%0d,%0d) z=%0d want (127,255) z=1",
                  log_ra[128], log_rb[128], log_z[129]);
      end
      total++;
      if ({log_we[4], log_we[5], log_wa[5], log_wb[5]} !== {1'b0, 1'b1, 32'd0, 32'd128}) begin
         bad++;
         $display("FAIL first write: got we4=%b we5=%b waddr (%0d,%0d) want 0 1 (0,128)",
                  log_we[4], log_we[5], log_wa[5], log_wb[5]);
      end
   endtask

   task automatic test_full_timing();
      total++;
      if ({log_we[924], log_we[925]} !== 2'b10) begin
         bad++;
         $display("FAIL last write: got we924=%b we925=%b want 1 0", log_we[924], log_we[925]);
      end
      total++;
      if ({log_done[924], log_done[925], log_done[926]} !== 3'b010) begin
         bad++;
         $display("FAIL done pulse: got %b%b%b want 010", log_done[924], log_done[925], log_done[926]);
      end
      total++;
      if ({log_busy[0], log_busy[1], log_busy[925], log_busy[926]} !== 4'b0110) begin
         bad++;
         $display("FAIL busy window: got %b%b%b%b want 0110", log_busy[0], log_busy[1],
                  log_busy[925], log_busy[926]);
      end
      total++;
      if ({log_ra[133], log_rb[133], log_z[134]} !== {32'd0, 32'd64, 32'd2}) begin
         bad++;
         $display("FAIL layer1 start: got (%0d,%0d) z=%0d want (0,64) z=2", log_ra[133], log_rb[133], log_z[134]);
      end
   endtask

   task automatic test_layer6();
      int kt [5] = '{0, 1, 2, 126, 127};
      int ra [5] = '{0, 1, 4, 252, 253};
      int rb [5] = '{2, 3, 6, 254, 255};
      int zt [5] = '{64, 64, 65, 127, 127};
      for (int i = 0; i < 5; i++) begin
         int c;
         c = 1 + 6 * PERIOD + kt[i];
         total++;
         if ({log_ra[c], log_rb[c], log_z[c+1]} !== {ra[i], rb[i], zt[i]}) begin
            bad++;
            $display("FAIL layer6 k=%0d: got (%0d,%0d) z=%0d want (%0d,%0d) z=%0d", kt[i],
                     log_ra[c], log_rb[c], log_z[c+1], ra[i], rb[i], zt[i]);
         end
      end
   endtask

   task automatic test_identity_back_to_back();
      int d;
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      img[0] = 32'd16; img[1] = 32'd20; img[128] = 32'd3; img[129] = 32'd5;
      load_mem();
      run_transform(1'b0, 0, 1'b1, d);
      total++;
      if (d !== 1) begin
         bad++;
         $display("FAIL back_to_back done count: got %0d want 1", d);
      end
      total++;
      if ({mem[0], mem[1], mem[128], mem[129]} !== {32'd16, 32'd20, 32'd3, 32'd5}) begin
         bad++;
         $display("FAIL identity words: got %0d %0d %0d %0d want 16 20 3 5", mem[0], mem[1], mem[128], mem[129]);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] snap [256];
      int act;
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      load_mem();
      bf_mode = 1;
      @(negedge clk); bus.start = 1'b1;
`ifdef NTT_INVERSE_EN
      bus.inv = 1'b0;
`endif
      @(negedge clk); bus.start = 1'b0;
      repeat (299) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.en_a, bus.en_b, bus.we_a, bus.we_b, bus.raddr_a, bus.raddr_b,
           bus.waddr_a, bus.waddr_b, bus.din_a, bus.din_b, bus.bf_valid_o, bus.bf_a_o, bus.bf_b_o,
           bus.zeta_idx} !== '0) begin
         bad++;
         $display("FAIL mid-run reset outputs: got nonzero (busy=%b en_a=%b we_a=%b) want all 0",
                  bus.busy, bus.en_a, bus.we_a);
      end
      for (int i = 0; i < 256; i++) snap[i] = mem[i];
      @(negedge clk); rst = 1'b0;
      act = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.we_a || bus.we_b || bus.en_a || bus.en_b || bus.busy) act++;
      end
      total++;
      if (act !== 0) begin
         bad++;
         $display("FAIL post-reset activity: got %0d active cycles want 0", act);
      end
      act = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) act++;
      total++;
      if (act !== 0) begin
         bad++;
         $display("FAIL post-reset memory: got %0d changed words want 0", act);
      end
   endtask

`ifdef NTT_INVERSE_EN
   task automatic test_inverse();
      int d;
      for (int i = 0; i < 256; i++) img[i] = $urandom;
      load_mem();
      run_transform(1'b1, 1, 1'b0, d);
      total++;
      if ({log_ra[1], log_rb[1], log_ra[2], log_rb[2], log_ra[3], log_rb[3]} !==
          {32'd0, 32'd2, 32'd1, 32'd3, 32'd4, 32'd6}) begin
         bad++;
         $display("FAIL inverse layer0 pairs: got (%0d,%0d)(%0d,%0d)(%0d,%0d) want (0,2)(1,3)(4,6)",
                  log_ra[1], log_rb[1], log_ra[2], log_rb[2], log_ra[3], log_rb[3]);
      end
      total++;
      if ({log_z[2], log_z[3], log_z[4]} !== {32'd127, 32'd127, 32'd126}) begin
         bad++;
         $display("FAIL inverse layer0 zeta: got %0d %0d %0d want 127 127 126", log_z[2], log_z[3], log_z[4]);
      end
      total++;
      if ({log_ra[793], log_rb[793], log_z[794], d} !== {32'd0, 32'd128, 32'd1, 32'd1}) begin
         bad++;
         $display("FAIL inverse layer6: got (%0d,%0d) z=%0d dones=%0d want (0,128) z=1 dones=1",
                  log_ra[793], log_rb[793], log_z[794], d);
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
`ifdef NTT_INVERSE_EN
      bus.inv = 1'b0;
`endif
      test_reset();
      test_forward_run();
      test_first_layer();
      test_full_timing();
      test_layer6();
      test_identity_back_to_back();
      test_reset_mid_run();
`ifdef NTT_INVERSE_EN
      test_inverse();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
